// File: rtl/tank_pkg.sv
// Shared tank definitions: direction encodings, screen coordinate widths, default colours.
// Latency: none (constants and types only).
// Backpressure: not applicable. Also used by the movement controller and the bullet logic.
package tank_pkg;

   localparam int X_W = 8;
   localparam int Y_W = 7;

   // moving_direction[2] marks the direction field as valid
   localparam int DIR_VALID_BIT = 2;

   localparam logic [1:0] DIR_UP    = 2'd0;
   localparam logic [1:0] DIR_DOWN  = 2'd1;
   localparam logic [1:0] DIR_LEFT  = 2'd2;
   localparam logic [1:0] DIR_RIGHT = 2'd3;

   localparam logic [2:0] COL_TANK = 3'b010;
   localparam logic [2:0] COL_MARK = 3'b111;
   localparam logic [2:0] COL_BG   = 3'b000;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_REQ,
      ST_ERASE,
      ST_DRAW,
      ST_MARK,
      ST_FIN
   } draw_state_t;

endpackage

// File: rtl/tank_drawer_scan.sv
// Row-major (col fastest) scanner over a SIZE x SIZE sprite, with a last-pixel flag.
// Latency: the counters advance one step per enabled cycle and wrap to (0,0) after the last pixel.
// Backpressure: with en=0 the position holds. Ports: clk, resetn, clear, en in; row, col, last out.
module sprite_scan #(
   parameter int SIZE = 9
) (
   input  logic       clk,
   input  logic       resetn,
   input  logic       clear,
   input  logic       en,
   output logic [3:0] row,
   output logic [3:0] col,
   output logic       last
);

   localparam logic [3:0] MAX = 4'(SIZE - 1);

   assign last = (row == MAX) && (col == MAX);

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         row <= '0;
         col <= '0;
      end else if (clear) begin
         row <= '0;
         col <= '0;
      end else if (en) begin
         if (col == MAX) begin
            col <= '0;
            // Wrapping to (0,0) lets DRAW follow ERASE without a separate clear.
            row <= last ? 4'd0 : row + 4'd1;
         end else begin
            col <= col + 4'd1;
         end
      end
   end

endmodule

// File: rtl/tank_drawer.sv
// Redraws one tank sprite whenever its position or facing changes: optional erase, then body, then marker.
// Latency: req rises one cycle after a change; each pixel appears one cycle after its granted cycle.
// Backpressure: grant=0 pauses the scan with plot low. Ports: clk/resetn, xpos/ypos/moving_direction, grant in; req, x_out/y_out/colour/plot, done out.
module tank_drawer
   import tank_pkg::*;
#(
   parameter int         TANK_SIZE   = 9,
   parameter logic [2:0] TANK_COLOUR = COL_TANK,
   parameter logic [2:0] MARK_COLOUR = COL_MARK,
   parameter logic [2:0] BG_COLOUR   = COL_BG
) (
   input  logic           clk,
   input  logic           resetn,
   input  logic [X_W-1:0] xpos,
   input  logic [Y_W-1:0] ypos,
   input  logic [2:0]     moving_direction,
   input  logic           grant,
   output logic           req,
   output logic [X_W-1:0] x_out,
   output logic [Y_W-1:0] y_out,
   output logic [2:0]     colour,
   output logic           plot,
   output logic           done
);

   localparam logic [X_W-1:0] HX = X_W'((TANK_SIZE - 1) / 2);
   localparam logic [X_W-1:0] EX = X_W'(TANK_SIZE - 1);
   localparam logic [Y_W-1:0] HY = Y_W'((TANK_SIZE - 1) / 2);
   localparam logic [Y_W-1:0] EY = Y_W'(TANK_SIZE - 1);

   draw_state_t state, state_nxt;

   logic [1:0]     face, face_eff;
   logic [X_W-1:0] drawn_x, new_x, mark_x, x_nxt;
   logic [Y_W-1:0] drawn_y, new_y, mark_y, y_nxt;
   logic [1:0]     drawn_face, new_face;
   logic           drawn_valid;
   logic           dirty, latch;
   logic           plot_nxt;
   logic [2:0]     colour_nxt;
   logic [3:0]     row, col;
   logic           last, scan_en, scan_clr;

   // Facing as it will be after this edge, so a direction change is picked up
   // with the same one-cycle latency as a position change.
   assign face_eff = moving_direction[DIR_VALID_BIT] ? moving_direction[1:0] : face;

   assign dirty = !drawn_valid || (xpos != drawn_x) || (ypos != drawn_y) ||
                  (face_eff != drawn_face);

   assign scan_clr = (state == ST_IDLE);

   sprite_scan #(.SIZE(TANK_SIZE)) u_scan (
      .clk    (clk),
      .resetn (resetn),
      .clear  (scan_clr),
      .en     (scan_en),
      .row    (row),
      .col    (col),
      .last   (last)
   );

   always_comb begin
      mark_x = new_x + HX;
      mark_y = new_y;
      case (new_face)
         DIR_UP:    begin mark_x = new_x + HX; mark_y = new_y;      end
         DIR_DOWN:  begin mark_x = new_x + HX; mark_y = new_y + EY; end
         DIR_LEFT:  begin mark_x = new_x;      mark_y = new_y + HY; end
         default:   begin mark_x = new_x + EX; mark_y = new_y + HY; end
      endcase
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) state <= ST_IDLE;
      else         state <= state_nxt;
   end

   always_comb begin
      state_nxt  = state;
      latch      = 1'b0;
      scan_en    = 1'b0;
      plot_nxt   = 1'b0;
      x_nxt      = x_out;
      y_nxt      = y_out;
      colour_nxt = colour;
      case (state)
         ST_IDLE: begin
            if (dirty) begin
               latch     = 1'b1;
               state_nxt = ST_REQ;
            end
         end
         ST_REQ: begin
            if (grant) state_nxt = drawn_valid ? ST_ERASE : ST_DRAW;
         end
         ST_ERASE: begin
            if (grant) begin
               scan_en    = 1'b1;
               plot_nxt   = 1'b1;
               x_nxt      = drawn_x + {4'b0000, col};
               y_nxt      = drawn_y + {3'b000, row};
               colour_nxt = BG_COLOUR;
               if (last) state_nxt = ST_DRAW;
            end
         end
         ST_DRAW: begin
            if (grant) begin
               scan_en    = 1'b1;
               plot_nxt   = 1'b1;
               x_nxt      = new_x + {4'b0000, col};
               y_nxt      = new_y + {3'b000, row};
               colour_nxt = TANK_COLOUR;
               if (last) state_nxt = ST_MARK;
            end
         end
         ST_MARK: begin
            if (grant) begin
               plot_nxt   = 1'b1;
               x_nxt      = mark_x;
               y_nxt      = mark_y;
               colour_nxt = MARK_COLOUR;
               state_nxt  = ST_FIN;
            end
         end
         ST_FIN:  state_nxt = ST_IDLE;
         default: state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         req         <= 1'b0;
         plot        <= 1'b0;
         done        <= 1'b0;
         x_out       <= '0;
         y_out       <= '0;
         colour      <= '0;
         face        <= DIR_UP;
         new_x       <= '0;
         new_y       <= '0;
         new_face    <= DIR_UP;
         drawn_x     <= '0;
         drawn_y     <= '0;
         drawn_face  <= DIR_UP;
         drawn_valid <= 1'b0;
      end else begin
         req    <= (state_nxt == ST_REQ) || (state_nxt == ST_ERASE) ||
                   (state_nxt == ST_DRAW) || (state_nxt == ST_MARK);
         plot   <= plot_nxt;
         done   <= (state == ST_FIN);
         x_out  <= x_nxt;
         y_out  <= y_nxt;
         colour <= colour_nxt;
         face   <= face_eff;
         if (latch) begin
            new_x    <= xpos;
            new_y    <= ypos;
            new_face <= face_eff;
         end
         if (state == ST_FIN) begin
            drawn_x     <= new_x;
            drawn_y     <= new_y;
            drawn_face  <= new_face;
            drawn_valid <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_tank_drawer.sv
module tb_tank_drawer;

   localparam int TS = 9;

   logic       clk = 1'b0;
   logic       resetn = 1'b0;
   logic [7:0] xpos = 8'd20;
   logic [6:0] ypos = 7'd30;
   logic [2:0] md = 3'b100;
   logic       grant = 1'b0;
   logic       req, plot, done;
   logic [7:0] x_out;
   logic [6:0] y_out;
   logic [2:0] colour;

   always #5 clk = ~clk;

   tank_drawer dut (
      .clk              (clk),
      .resetn           (resetn),
      .xpos             (xpos),
      .ypos             (ypos),
      .moving_direction (md),
      .grant            (grant),
      .req              (req),
      .x_out            (x_out),
      .y_out            (y_out),
      .colour           (colour),
      .plot             (plot),
      .done             (done)
   );

   typedef struct packed {
      logic [7:0] x;
      logic [6:0] y;
      logic [2:0] c;
   } pix_t;

   int   total = 0;
   int   bad = 0;
   pix_t got[$];
   pix_t exp_q[$];
   int   done_cnt = 0, cyc = 0, first_plot_cyc = -1, done_cyc = -1, plot_nogrant = 0;
   logic g_edge = 1'b0;

   // reference state: what the bench believes is on screen
   logic       m_valid = 1'b0;
   logic [7:0] m_x = 8'd0;
   logic [6:0] m_y = 7'd0;
   logic [1:0] m_face = 2'd0;
   logic [1:0] m_freg = 2'd0;

   always @(posedge clk) g_edge = grant;

   always @(negedge clk) begin
      cyc++;
      if (plot) begin
         if (first_plot_cyc < 0) first_plot_cyc = cyc;
         got.push_back(pix_t'({x_out, y_out, colour}));
         if (!g_edge) plot_nogrant++;
      end
      if (done) begin
         done_cnt++;
         done_cyc = cyc;
      end
   end

   function automatic void add_square(logic [7:0] ox, logic [6:0] oy, logic [2:0] c);
      for (int r = 0; r < TS; r++)
         for (int k = 0; k < TS; k++)
            exp_q.push_back(pix_t'({8'(ox + k), 7'(oy + r), c}));
   endfunction

   // Append one complete redraw to the expectation and advance the on-screen model.
   function automatic void expect_redraw(logic [7:0] nx, logic [6:0] ny, logic [1:0] f);
      int h, e;
      h = (TS - 1) / 2;
      e = TS - 1;
      if (m_valid) add_square(m_x, m_y, 3'b000);
      add_square(nx, ny, 3'b010);
      case (f)
         2'd0: exp_q.push_back(pix_t'({8'(nx + h), ny, 3'b111}));
         2'd1: exp_q.push_back(pix_t'({8'(nx + h), 7'(ny + e), 3'b111}));
         2'd2: exp_q.push_back(pix_t'({nx, 7'(ny + h), 3'b111}));
         default: exp_q.push_back(pix_t'({8'(nx + e), 7'(ny + h), 3'b111}));
      endcase
      m_valid = 1'b1;
      m_x = nx;
      m_y = ny;
      m_face = f;
   endfunction

   function automatic logic [1:0] next_face(logic [2:0] d, logic [1:0] cur);
      return d[2] ? d[1:0] : cur;
   endfunction

   task automatic clear_mon();
      got.delete();
      exp_q.delete();
      done_cnt = 0;
      first_plot_cyc = -1;
      done_cyc = -1;
      plot_nogrant = 0;
   endtask

   // gmode: 0 = grant always, 1 = toggle each cycle, 2 = random
   task automatic run_until_done(input int gmode, input int ndone, input string name);
      int n;
      n = 0;
      while (done_cnt < ndone && n < 3000) begin
         @(negedge clk);
         #1;
         case (gmode)
            0: grant = 1'b1;
            1: grant = ~grant;
            default: grant = ($urandom_range(0, 9) < 7);
         endcase
         n++;
      end
      total++;
      if (done_cnt < ndone) begin
         bad++;
         $display("FAIL %s_timeout: done pulses=%0d required=%0d", name, done_cnt, ndone);
      end
      @(negedge clk);
      #1;
      grant = 1'b1;
   endtask

   task automatic compare_pixels(input string name, input int ndone);
      int idx;
      total++;
      if (got.size() !== exp_q.size()) begin
         bad++;
         $display("FAIL %s_count: plots=%0d required=%0d", name, got.size(), exp_q.size());
      end
      idx = -1;
      for (int i = 0; i < got.size() && i < exp_q.size(); i++)
         if (idx < 0 && got[i] !== exp_q[i]) idx = i;
      total++;
      if (idx >= 0) begin
         bad++;
         $display("FAIL %s_pixel[%0d]: got x=%0d y=%0d c=%b required x=%0d y=%0d c=%b", name, idx,
                  got[idx].x, got[idx].y, got[idx].c, exp_q[idx].x, exp_q[idx].y, exp_q[idx].c);
      end
      total++;
      if (done_cnt !== ndone) begin
         bad++;
         $display("FAIL %s_done: pulses=%0d required=%0d", name, done_cnt, ndone);
      end
      total++;
      if (plot_nogrant !== 0) begin
         bad++;
         $display("FAIL %s_plot_without_grant: count=%0d required=0", name, plot_nogrant);
      end
   endtask

   task automatic do_redraw(input logic [7:0] nx, input logic [6:0] ny, input logic [2:0] d,
                            input int gmode, input string name);
      @(negedge clk);
      #1;
      clear_mon();
      xpos = nx;
      ypos = ny;
      md = d;
      m_freg = next_face(d, m_freg);
      expect_redraw(nx, ny, m_freg);
      run_until_done(gmode, 1, name);
      compare_pixels(name, 1);
   endtask

   task automatic test_reset();
      resetn = 1'b0;
      grant = 1'b0;
      #2;
      total++;
      if ({req, plot, done} !== 3'b000) begin
         bad++;
         $display("FAIL reset_ctrl: req/plot/done=%b required=000", {req, plot, done});
      end
      total++;
      if ({x_out, y_out, colour} !== 18'd0) begin
         bad++;
         $display("FAIL reset_pixel: x=%0d y=%0d c=%b required all 0", x_out, y_out, colour);
      end
      repeat (3) @(negedge clk);
      total++;
      if (req !== 1'b0) begin
         bad++;
         $display("FAIL reset_req_held: req=%b required=0", req);
      end
   endtask

   task automatic test_first_draw();
      @(negedge clk);
      #1;
      clear_mon();
      xpos = 8'd20;
      ypos = 7'd30;
      md = 3'b100;
      grant = 1'b1;
      resetn = 1'b1;
      m_valid = 1'b0;
      m_freg = next_face(md, 2'd0);
      expect_redraw(xpos, ypos, m_freg);
      @(negedge clk);
      total++;
      if (req !== 1'b1) begin
         bad++;
         $display("FAIL first_req_latency: req=%b required=1", req);
      end
      run_until_done(0, 1, "first");
      compare_pixels("first", 1);
      total++;
      if (got.size() == 82 && (got[0] !== pix_t'({8'd20, 7'd30, 3'b010}) ||
          got[80] !== pix_t'({8'd28, 7'd38, 3'b010}) || got[81] !== pix_t'({8'd24, 7'd30, 3'b111}))) begin
         bad++;
         $display("FAIL first_corners: first=%h last=%h mark=%h", got[0], got[80], got[81]);
      end
      total++;
      if (done_cyc - first_plot_cyc !== 82) begin
         bad++;
         $display("FAIL first_span: cycles=%0d required=82", done_cyc - first_plot_cyc);
      end
      total++;
      if (req !== 1'b0) begin
         bad++;
         $display("FAIL first_idle_req: req=%b required=0", req);
      end
   endtask

   task automatic test_face();
      do_redraw(8'd20, 7'd30, 3'b111, 0, "face");
      total++;
      if (got.size() != 163 || got[162] !== pix_t'({8'd28, 7'd34, 3'b111})) begin
         bad++;
         $display("FAIL face_marker: plots=%0d last=%h required 163 and mark (28,34)",
                  got.size(), got.size() > 0 ? got[got.size() - 1] : 18'h0);
      end
   endtask

   task automatic test_move();
      do_redraw(8'd20, 7'd29, 3'b100, 0, "move");
      total++;
      if (got.size() != 163 || got[162] !== pix_t'({8'd24, 7'd29, 3'b111}) ||
          got[0] !== pix_t'({8'd20, 7'd30, 3'b000})) begin
         bad++;
         $display("FAIL move_shape: plots=%0d required 163 with erase at (20,30) and mark (24,29)",
                  got.size());
      end
      total++;
      if (done_cyc - first_plot_cyc !== 163) begin
         bad++;
         $display("FAIL move_span: cycles=%0d required=163", done_cyc - first_plot_cyc);
      end
   endtask

   task automatic test_toggle();
      int span;
      do_redraw(8'd40, 7'd50, 3'b110, 1, "toggle");
      span = done_cyc - first_plot_cyc;
      total++;
      if (span < 2 * 163 - 2 || span > 2 * 163 + 1) begin
         bad++;
         $display("FAIL toggle_span: cycles=%0d required about %0d", span, 2 * 163);
      end
   endtask

   task automatic test_wrap();
      logic [7:0] xs[9];
      int base;
      xs = '{8'd252, 8'd253, 8'd254, 8'd255, 8'd0, 8'd1, 8'd2, 8'd3, 8'd4};
      do_redraw(8'd252, 7'd10, 3'b100, 0, "wrap");
      base = got.size() - 82;
      for (int i = 0; i < 9; i++) begin
         total++;
         if (base < 0 || got[base + i].x !== xs[i]) begin
            bad++;
            $display("FAIL wrap_x[%0d]: got=%0d required=%0d", i,
                     base < 0 ? -1 : int'(got[base + i].x), xs[i]);
         end
      end
   endtask

   task automatic test_back_to_back();
      int n;
      logic [1:0] fa;
      @(negedge clk);
      #1;
      clear_mon();
      xpos = 8'd70;
      ypos = 7'd20;
      md = 3'b110;
      fa = next_face(md, m_freg);
      expect_redraw(xpos, ypos, fa);
      n = 0;
      while (got.size() < 50 && n < 500) begin
         @(negedge clk);
         #1;
         n++;
      end
      xpos = 8'd71;
      ypos = 7'd22;
      md = 3'b101;
      m_freg = next_face(md, fa);
      expect_redraw(xpos, ypos, m_freg);
      run_until_done(2, 2, "b2b");
      compare_pixels("b2b", 2);
   endtask

   task automatic test_reset_mid();
      int n;
      @(negedge clk);
      #1;
      clear_mon();
      xpos = 8'd60;
      ypos = 7'd60;
      md = 3'b101;
      grant = 1'b1;
      n = 0;
      while (got.size() < 81 + 40 && n < 500) begin
         @(negedge clk);
         #1;
         n++;
      end
      resetn = 1'b0;
      #1;
      total++;
      if ({req, plot, done, x_out, y_out, colour} !== 21'd0) begin
         bad++;
         $display("FAIL midreset_outputs: req=%b plot=%b x=%0d y=%0d c=%b required all 0",
                  req, plot, x_out, y_out, colour);
      end
      @(negedge clk);
      #1;
      clear_mon();
      resetn = 1'b1;
      m_valid = 1'b0;
      m_freg = next_face(md, 2'd0);
      expect_redraw(xpos, ypos, m_freg);
      run_until_done(0, 1, "midreset");
      compare_pixels("midreset", 1);
      total++;
      if (got.size() == 0 || got[0] !== pix_t'({8'd60, 7'd60, 3'b010})) begin
         bad++;
         $display("FAIL midreset_start: first=%h required (60,60,010)",
                  got.size() > 0 ? got[0] : 18'h0);
      end
   endtask

   task automatic test_random();
      logic [7:0] nx;
      logic [6:0] ny;
      logic [2:0] d;
      logic [1:0] fr;
      for (int it = 0; it < 10; it++) begin
         if ($urandom_range(0, 3) == 0) begin
            nx = m_x;
            ny = m_y;
            d = {1'b0, 2'($urandom)};
         end else begin
            nx = 8'($urandom);
            ny = 7'($urandom);
            d = 3'($urandom);
         end
         fr = next_face(d, m_freg);
         if (!m_valid || nx != m_x || ny != m_y || fr != m_face) begin
            do_redraw(nx, ny, d, 2, "random");
         end else begin
            @(negedge clk);
            #1;
            clear_mon();
            xpos = nx;
            ypos = ny;
            md = d;
            m_freg = fr;
            grant = 1'b1;
            repeat (20) @(negedge clk);
            total++;
            if (got.size() !== 0 || req !== 1'b0) begin
               bad++;
               $display("FAIL random_quiet: plots=%0d req=%b required 0 and 0", got.size(), req);
            end
         end
      end
   endtask

   initial begin
      test_reset();
      test_first_draw();
      test_face();
      test_move();
      test_toggle();
      test_wrap();
      test_back_to_back();
      test_reset_mid();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/tank_drawer.md
# tank_drawer

Renders one tank on the shared 160x120 VGA frame buffer. Sits directly downstream of the tank movement controller: watches its `xpos`/`ypos`/`moving_direction` outputs and, whenever the position or facing changes, erases the tank's previous square and draws it at its new position with a facing marker. Arbitrates for the frame-buffer write port with a req/grant handshake.

## Interface
Parameters:
- `TANK_SIZE`, 9, side of the square sprite in pixels; valid range 3..15, odd only
- `TANK_COLOUR`, 3'b010, body colour
- `MARK_COLOUR`, 3'b111, facing-marker colour
- `BG_COLOUR`, 3'b000, erase colour

Ports:
- `clk` in 1: system clock
- `resetn` in 1: asynchronous, active-low reset
- `xpos` in 8: tank top-left x, from movement controller
- `ypos` in 7: tank top-left y
- `moving_direction` in 3: bit2 = valid; [1:0] = 0 up, 1 down, 2 left, 3 right
- `grant` in 1: frame-buffer port granted this cycle
- `req` out 1: request for frame-buffer port
- `x_out` out 8: pixel x
- `y_out` out 7: pixel y
- `colour` out 3: pixel colour
- `plot` out 1: write strobe for the pixel
- `done` out 1: one-cycle pulse when a redraw finishes

## Operation
- Internal registers: `drawn_x`, `drawn_y`, `drawn_face` hold the last rendered state; `drawn_valid` is 0 after reset.
- `face` register: loads `moving_direction[1:0]` when `moving_direction[2]`=1; otherwise holds. Reset value 0 (up).
- Dirty = !`drawn_valid` OR (`xpos`,`ypos`,`face`) != (`drawn_x`,`drawn_y`,`drawn_face`).
- FSM states: IDLE, REQ, ERASE, DRAW, MARK, FIN.
  - IDLE: if dirty, latch `new_x`/`new_y`/`new_face` from current inputs, go to REQ.
  - REQ: `req`=1; on `grant`, go to ERASE if `drawn_valid`, else DRAW.
  - ERASE: TANK_SIZE² pixels at `drawn_x`/`drawn_y`, `BG_COLOUR`, row-major (col fastest). Then go to DRAW.
  - DRAW: TANK_SIZE² pixels at `new_x`/`new_y`, `TANK_COLOUR`, row-major. Then go to MARK.
  - MARK: one pixel, `MARK_COLOUR`. Let h=(TANK_SIZE-1)/2 and e=TANK_SIZE-1:
    - up: (new_x+h, new_y)
    - down: (new_x+h, new_y+e)
    - left: (new_x, new_y+h)
    - right: (new_x+e, new_y+h)
  - FIN: `done`=1; commit `new_*` into `drawn_*`; set `drawn_valid`=1; go to IDLE.
- `req` stays 1 from REQ through MARK inclusive.
- In ERASE, DRAW and MARK, a pixel is emitted and the counters advance only in cycles with `grant`=1. With `grant`=0: `plot`=0, counters and coordinates hold (pause, no restart).
- Input changes after the latch are ignored until FIN. Dirty is re-evaluated in IDLE, so a change that arrives mid-redraw triggers a new redraw on return.
- Arithmetic: x wraps mod 256 and y wraps mod 128. There is no clipping; the frame buffer ignores off-screen writes.

## Timing
- Reset (async, all outputs): `req`=0, `plot`=0, `done`=0, `x_out`=0, `y_out`=0, `colour`=0. State = IDLE, `drawn_valid`=0, `face`=0.
- Reset asserted mid-redraw aborts immediately. On release, the first redraw is a draw-only (no erase), because `drawn_valid`=0.
- Input change at edge N: latched in IDLE at edge N+1; `req` high from N+1.
- All outputs are registered. `plot`, `x_out`, `y_out` and `colour` are valid together, one cycle after the granted cycle that produced them.
- Granted-cycle counts:
  - Full redraw: 2·TANK_SIZE²+1 granted cycles (163 at default).
  - First draw: TANK_SIZE²+1 granted cycles (82 at default).
  - `done` rises the cycle after the MARK pixel's `plot`.
- Minimum idle between redraws: 1 cycle (FIN→IDLE).

## Structure
- Shared package `tank_pkg`:
  - direction encodings (`DIR_UP`..`DIR_RIGHT`, valid-bit position)
  - screen widths (`X_W`=8, `Y_W`=7)
  - default colour constants
  - This package is also used by the movement controller and the bullet logic.
- One sub-module, `sprite_scan`: a row/col counter with enable and a last-pixel flag, parameterised by TANK_SIZE. It is instantiated once and reused by ERASE and DRAW.
- The FSM and coordinate muxing live in `tank_drawer`.

## Test plan
- Reset release, grant=1, xpos=20, ypos=30, face up: 81 plots of colour 010 covering x 20..28, y 30..38 (first (20,30), last (28,38)). Then marker at (24,30) colour 111. Then `done`; no erase pixels.
- After the above, ypos→29 with moving_direction=3'b100: 81 erase plots at (20..28,30..38) colour 000, then 81 draw plots at y 29..37. Marker at (24,29). 163 plots total.
- moving_direction=3'b111 with position unchanged: full redraw at the same square; marker moves to (28,34) for a tank at (20,30).
- Toggle grant 1/0 every cycle during DRAW: pixel sequence is identical to the continuous case; `plot` is never high when the prior cycle's grant was 0; duration doubles.
- xpos=252 draw: x_out sequence is 252,253,254,255,0,1,2,3,4 per row.
- Assert resetn low at DRAW pixel 40: outputs go to 0 immediately. After release, the next redraw has no erase and starts at (xpos,ypos).
